// File: rtl/subckt_bist_driver_pkg.sv
`default_nettype none
// ============================================================================
// Module      : subckt_bist_driver_pkg
// Description : Shared definitions for the sub-circuit BIST driver: the FSM
//               state type, the LFSR/MISR feedback tap mask and the seed
//               substituted for an all-zero (lock-up) seed.
// Revision    : 1.0 - initial release
// ============================================================================
package subckt_bist_driver_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // x^16 + x^14 + x^13 + x^11 + 1 expressed as a mask over state bits 15..0
    localparam logic [15:0] c_POLY_TAP    = 16'hB400;
    localparam logic [15:0] c_LOCKUP_SEED = 16'hACE1;

    // An all-zero state never leaves zero, so it is swapped for a safe seed.
    function automatic logic [15:0] fix_seed(input logic [15:0] i_seed);
        return (i_seed == 16'h0000) ? c_LOCKUP_SEED : i_seed;
    endfunction

endpackage
`default_nettype wire

// File: rtl/subckt_bist_driver_lfsr16.sv
`default_nettype none
// ============================================================================
// Module      : bist_lfsr16
// Description : 16-bit Fibonacci shift register using the package tap mask.
//               Used both as a pattern generator (serial input 0) and as a
//               single-input signature register (serial input = response).
// Ports       : clk        - clock, rising edge
//               rst_n      - asynchronous active-low reset
//               i_load     - synchronous load of i_load_val (wins over shift)
//               i_load_val - value to load
//               i_shift    - advance one step
//               i_serial   - bit XORed into the feedback entering bit 0
//               o_state    - current register contents
// Revision    : 1.0 - initial release
// ============================================================================
module bist_lfsr16
    import subckt_bist_driver_pkg::*;
#(
    parameter logic [15:0] RESET_VAL = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_load,
    input  logic [15:0] i_load_val,
    input  logic        i_shift,
    input  logic        i_serial,
    output logic [15:0] o_state
);

    logic [15:0] r_state;
    logic        w_fb;

    assign w_fb = (^(r_state & c_POLY_TAP)) ^ i_serial;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RESET_VAL;
        end else if (i_load) begin
            r_state <= i_load_val;
        end else if (i_shift) begin
            r_state <= {r_state[14:0], w_fb};
        end
    end

    assign o_state = r_state;

endmodule
`default_nettype wire

// File: rtl/subckt_bist_driver.sv
`default_nettype none
// ============================================================================
// Module      : subckt_bist_driver
// Description : BIST driver for a 5-input, 1-output sub-circuit. Applies
//               pat_count LFSR patterns, compacts each response LAT cycles
//               after its pattern into a MISR and compares the signature
//               with a golden value.
// Ports       : I1470_clk    - clock, rising edge
//               I1477_rst    - asynchronous active-low reset
//               start        - run request (honoured in IDLE/DONE only)
//               seed         - LFSR seed, sampled on accepted start
//               pat_count    - number of patterns, sampled on accepted start
//               expected_sig - golden signature
//               dut_resp     - response bit from the sub-circuit
//               stim_out     - pattern bits to the sub-circuit
//               busy         - high in RUN and FLUSH
//               done         - high in DONE
//               pass         - signature matches expected_sig (while done)
//               signature    - MISR contents
// Revision    : 1.0 - initial release
// ============================================================================
module subckt_bist_driver
    import subckt_bist_driver_pkg::*;
#(
    parameter int LAT   = 3,
    parameter int PAT_W = 10
) (
    input  logic             I1470_clk,
    input  logic             I1477_rst,
    input  logic             start,
    input  logic [15:0]      seed,
    input  logic [PAT_W-1:0] pat_count,
    input  logic [15:0]      expected_sig,
    input  logic             dut_resp,
    output logic [4:0]       stim_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      signature
);

    localparam logic [2:0] c_LAT = 3'(LAT);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [PAT_W-1:0] r_pat_cnt;
    logic [2:0]       r_flush_cnt;
    logic [LAT-1:0]   r_cap;

    logic             w_accept;
    logic             w_run;
    logic             w_last_pat;
    logic             w_capture;
    logic [15:0]      w_lfsr;
    logic             w_unused_lfsr_hi;

    assign w_accept   = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_run      = (r_state == ST_RUN);
    // r_pat_cnt counts patterns still to issue, including the current one
    assign w_last_pat = w_run && (r_pat_cnt == PAT_W'(1));
    assign w_capture  = r_cap[LAT-1];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge I1470_clk or negedge I1477_rst) begin
        if (!I1477_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        stim_out    = 5'b00000;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                done = (r_state == ST_DONE);
                if (w_accept) begin
                    w_state_nxt = (pat_count == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                busy     = 1'b1;
                stim_out = w_lfsr[4:0];
                if (w_last_pat) begin
                    w_state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                busy = 1'b1;
                if (r_flush_cnt == 3'd1) begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign pass = done && (signature == expected_sig);

    // ------------------------------------------------------------------
    // Pattern and flush counters
    // ------------------------------------------------------------------
    always_ff @(posedge I1470_clk or negedge I1477_rst) begin
        if (!I1477_rst) begin
            r_pat_cnt   <= '0;
            r_flush_cnt <= 3'd0;
        end else begin
            if (w_accept) begin
                r_pat_cnt <= pat_count;
            end else if (w_run) begin
                r_pat_cnt <= r_pat_cnt - PAT_W'(1);
            end

            if (w_last_pat) begin
                r_flush_cnt <= c_LAT;
            end else if ((r_state == ST_FLUSH) && (r_flush_cnt != 3'd0)) begin
                r_flush_cnt <= r_flush_cnt - 3'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Capture-enable pipeline: a RUN cycle's mark reaches the top stage
    // exactly LAT cycles later, when that pattern's response is present.
    // ------------------------------------------------------------------
    generate
        if (LAT == 1) begin : g_cap_single
            always_ff @(posedge I1470_clk or negedge I1477_rst) begin
                if (!I1477_rst) begin
                    r_cap <= '0;
                end else begin
                    r_cap[0] <= w_run;
                end
            end
        end else begin : g_cap_multi
            always_ff @(posedge I1470_clk or negedge I1477_rst) begin
                if (!I1477_rst) begin
                    r_cap <= '0;
                end else begin
                    r_cap <= {r_cap[LAT-2:0], w_run};
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Pattern generator and response compactor
    // ------------------------------------------------------------------
    bist_lfsr16 #(
        .RESET_VAL (c_LOCKUP_SEED)
    ) u_pat_lfsr (
        .clk        (I1470_clk),
        .rst_n      (I1477_rst),
        .i_load     (w_accept),
        .i_load_val (fix_seed(seed)),
        .i_shift    (w_run),
        .i_serial   (1'b0),
        .o_state    (w_lfsr)
    );

    bist_lfsr16 #(
        .RESET_VAL (16'h0000)
    ) u_misr (
        .clk        (I1470_clk),
        .rst_n      (I1477_rst),
        .i_load     (w_accept),
        .i_load_val (16'h0000),
        .i_shift    (w_capture),
        .i_serial   (dut_resp),
        .o_state    (signature)
    );

    // Only the low five pattern bits reach the sub-circuit.
    assign w_unused_lfsr_hi = ^w_lfsr[15:5];

endmodule
`default_nettype wire

// File: tb/tb_subckt_bist_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_subckt_bist_driver
// Description : Self-checking bench for subckt_bist_driver. A reference model
//               builds the expected pattern list and signature from the
//               recorded per-cycle responses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_subckt_bist_driver;

    localparam int TB_LAT   = 3;
    localparam int TB_PAT_W = 10;

    logic                I1470_clk = 1'b0;
    logic                I1477_rst = 1'b0;
    logic                start     = 1'b0;
    logic [15:0]         seed      = 16'h0;
    logic [TB_PAT_W-1:0] pat_count = '0;
    logic [15:0]         expected_sig = 16'h0;
    logic                dut_resp  = 1'b0;
    logic [4:0]          stim_out;
    logic                busy;
    logic                done;
    logic                pass;
    logic [15:0]         signature;

    int n_tests = 0;
    int n_fail  = 0;

    subckt_bist_driver #(
        .LAT   (TB_LAT),
        .PAT_W (TB_PAT_W)
    ) u_dut (
        .I1470_clk    (I1470_clk),
        .I1477_rst    (I1477_rst),
        .start        (start),
        .seed         (seed),
        .pat_count    (pat_count),
        .expected_sig (expected_sig),
        .dut_resp     (dut_resp),
        .stim_out     (stim_out),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .signature    (signature)
    );

    always #5 I1470_clk = ~I1470_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, ".stim"}, 32'(stim_out), 32'h0);
        check({tag, ".busy"}, 32'(busy), 32'h0);
        check({tag, ".done"}, 32'(done), 32'h0);
        check({tag, ".pass"}, 32'(pass), 32'h0);
        check({tag, ".sig"},  32'(signature), 32'h0);
    endtask

    // One step of the x^16+x^14+x^13+x^11+1 Fibonacci register, new bit at 0.
    function automatic logic [15:0] poly_step(input logic [15:0] v, input logic in_bit);
        logic fb;
        fb = v[15] ^ v[13] ^ v[12] ^ v[10] ^ in_bit;
        return {v[14:0], fb};
    endfunction

    // Complete run from an idle/done state; called at a falling edge.
    task automatic run_test(input logic [15:0] s, input int n, input int restart_cyc,
                            input bit resp_zero);
        logic [15:0] lf;
        logic [15:0] model_sig;
        logic        resp [0:63];
        logic [4:0]  pats [$];
        logic [4:0]  exp_stim;

        // expected pattern list from the seed
        lf = (s == 16'h0000) ? 16'hACE1 : s;
        for (int k = 0; k < n; k++) begin
            pats.push_back(lf[4:0]);
            lf = poly_step(lf, 1'b0);
        end

        start     = 1'b1;
        seed      = s;
        pat_count = TB_PAT_W'(n);
        dut_resp  = resp_zero ? 1'b0 : 1'($urandom);
        @(negedge I1470_clk);
        start     = 1'b0;
        seed      = 16'($urandom);
        pat_count = TB_PAT_W'($urandom);

        for (int c = 1; c <= n + TB_LAT; c++) begin
            exp_stim = (c <= n) ? pats[c-1] : 5'b00000;
            check("run.busy", 32'(busy), 32'h1);
            check("run.done", 32'(done), 32'h0);
            check("run.stim", 32'(stim_out), 32'(exp_stim));
            start    = (c == restart_cyc);
            resp[c]  = resp_zero ? 1'b0 : 1'($urandom);
            dut_resp = resp[c];
            @(negedge I1470_clk);
        end
        start = 1'b0;

        // response of pattern k (issued in run cycle k) is taken in cycle k+LAT
        model_sig = 16'h0000;
        for (int k = 1; k <= n; k++) begin
            model_sig = poly_step(model_sig, resp[k + TB_LAT]);
        end

        check("end.busy", 32'(busy), 32'h0);
        check("end.done", 32'(done), 32'h1);
        check("end.stim", 32'(stim_out), 32'h0);
        check("end.sig",  32'(signature), 32'(model_sig));
        expected_sig = model_sig;
        #1;
        check("end.pass_match", 32'(pass), 32'h1);
        expected_sig = model_sig ^ (16'h1 << $urandom_range(0, 15));
        #1;
        check("end.pass_miss", 32'(pass), 32'h0);

        // DONE must hold regardless of further response activity
        dut_resp = 1'b1;
        repeat (2) @(negedge I1470_clk);
        check("hold.done", 32'(done), 32'h1);
        check("hold.sig",  32'(signature), 32'(model_sig));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        // reset held for three cycles
        repeat (3) @(negedge I1470_clk);
        check_quiet("reset_held");
        I1477_rst = 1'b1;
        @(negedge I1470_clk);
        check_quiet("reset_released");

        // zero-pattern run goes straight to DONE
        start     = 1'b1;
        seed      = 16'h1234;
        pat_count = '0;
        @(negedge I1470_clk);
        start        = 1'b0;
        expected_sig = 16'h0000;
        #1;
        check("zero.done", 32'(done), 32'h1);
        check("zero.busy", 32'(busy), 32'h0);
        check("zero.sig",  32'(signature), 32'h0);
        check("zero.pass", 32'(pass), 32'h1);
        @(negedge I1470_clk);

        // four patterns, seed 1, response tied low
        run_test(16'h0001, 4, 0, 1'b1);
        // zero seed is replaced by the lock-up seed
        run_test(16'h0000, 5, 0, 1'b0);
        // start during RUN is ignored
        run_test(16'($urandom), 8, 3, 1'b0);
        // single-pattern boundary
        run_test(16'($urandom), 1, 0, 1'b0);

        // reset in cycle 2 of a ten-pattern run
        start     = 1'b1;
        seed      = 16'h5A5A;
        pat_count = TB_PAT_W'(10);
        dut_resp  = 1'b1;
        @(negedge I1470_clk);
        start = 1'b0;
        @(negedge I1470_clk);
        I1477_rst = 1'b0;
        #1;
        check_quiet("midrun_reset");
        repeat (2) @(negedge I1470_clk);
        I1477_rst = 1'b1;
        repeat (TB_LAT + 2) @(negedge I1470_clk);
        check_quiet("after_abort");
        run_test(16'h5A5A, 10, 0, 1'b0);

        // randomized runs
        for (int r = 0; r < 6; r++) begin
            run_test((r == 2) ? 16'h0000 : 16'($urandom), $urandom_range(1, 20), 0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/subckt_bist_driver.md
SUBCKT_BIST_DRIVER -- requirements
Module: subckt_bist_driver

Interface
REQ-001 Parameter LAT, default 3, SHALL set the DUT clock-to-response latency in cycles, range 1..7.
REQ-002 Parameter PAT_W, default 10, SHALL set the width of the pattern-count input.
REQ-003 I1470_clk  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-004 I1477_rst  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 start  input  1  SHALL request a test run; sampled only in IDLE or DONE.
REQ-006 seed  input  16  SHALL be the LFSR seed, sampled on accepted start.
REQ-007 pat_count  input  PAT_W  SHALL be the number of patterns to apply, sampled on accepted start.
REQ-008 expected_sig  input  16  SHALL be the golden signature compared at end of run.
REQ-009 dut_resp  input  1  SHALL be the single-bit response from the subcircuit under test.
REQ-010 stim_out  output  5  SHALL drive the five data inputs of the subcircuit under test.
REQ-011 busy  output  1  SHALL be high in RUN and FLUSH.
REQ-012 done  output  1  SHALL be high in DONE.
REQ-013 pass  output  1  SHALL be valid while done=1: high iff signature equals expected_sig.
REQ-014 signature  output  16  SHALL be the MISR contents.

Function
REQ-015 FSM states SHALL be IDLE, RUN, FLUSH, DONE.
REQ-016 IDLE/DONE with start=1 SHALL load the LFSR from seed, clear the MISR to 0x0000, load the pattern counter from pat_count, and enter RUN; if pat_count=0, enter DONE directly.
REQ-017 start while busy=1 SHALL be ignored.
REQ-018 A seed of 0x0000 SHALL be replaced by 0xACE1 to avoid LFSR lock-up.
REQ-019 The LFSR SHALL be 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1, shifting one step per RUN cycle.
REQ-020 stim_out SHALL equal lfsr[4:0] in RUN and 5'b00000 in all other states.
REQ-021 The first pattern SHALL appear on stim_out in the first RUN cycle, which is the cycle after the accepted start.
REQ-022 RUN SHALL last exactly pat_count cycles, then enter FLUSH.
REQ-023 FLUSH SHALL last exactly LAT cycles, then enter DONE.
REQ-024 A capture-enable pipeline of depth LAT SHALL mark valid responses; dut_resp SHALL be compacted exactly pat_count times, LAT cycles after each pattern.
REQ-025 Each compaction SHALL shift the MISR using the REQ-019 polynomial, with dut_resp XORed into bit 0.
REQ-026 DONE SHALL hold signature, done and pass until the next accepted start.

Reset
REQ-027 While I1477_rst=0, the block SHALL hold: state IDLE, LFSR 0xACE1, MISR 0x0000, counters 0, capture pipeline cleared, all outputs 0.
REQ-028 Reset asserted mid-run SHALL abort the run with no residual capture after release.
REQ-029 Reset release SHALL take effect on the next clock edge.

Structure
REQ-030 A shared package SHALL hold the state enum, the polynomial tap constant 16'hB400, and the lock-up seed 16'hACE1.
REQ-031 One sub-module, bist_lfsr16, SHALL be instantiated twice: as the pattern LFSR (serial input 0) and as the MISR (serial input dut_resp).
REQ-032 All flops SHALL use the asynchronous active-low reset.

Verification
REQ-033 Reset held low for 3 cycles, then released -> stim_out=0, busy=0, done=0, signature=0x0000.
REQ-034 pat_count=0, start pulse -> done=1 on the next cycle, signature=0x0000; with expected_sig=0x0000, pass=1.
REQ-035 seed=0x0001, pat_count=4, dut_resp tied 0 -> busy for 4+LAT cycles, stim_out=5'b00001 in the first RUN cycle, final signature=0x0000, pass=1 against 0x0000.
REQ-036 seed=0x0000 -> the first RUN stim_out=5'b00001 (from 0xACE1).
REQ-037 start re-asserted during RUN -> no restart; RUN length is unchanged.
REQ-038 Reset asserted in cycle 2 of a 10-pattern run -> all outputs 0 within the same cycle; a new start afterwards runs cleanly and matches the reference-model signature.
